// File: rtl/axis_peak_burst_sched_if.sv
// AXI-Stream beat channel used for both sides of the peak burst scheduler.
// The master modport drives the beat; the slave modport returns tready.
interface axis_peak_burst_sched_if #(
   parameter int unsigned DATA_WIDTH = 128
) ();
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_peak_burst_sched.sv
// Burst scheduler: forwards whole tlast-delimited bursts from the peak detector
// while armed, enforces a holdoff between bursts, and drains/counts the rest.
module axis_peak_burst_sched #(
   parameter int unsigned DATA_WIDTH    = 128,
   parameter int unsigned HOLDOFF_WIDTH = 16,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       disarm,
   input  logic [COUNT_WIDTH-1:0]     cfg_num_bursts,
   input  logic [HOLDOFF_WIDTH-1:0]   cfg_holdoff,
   axis_peak_burst_sched_if.slave     s_axis,
   axis_peak_burst_sched_if.master    m_axis,
   output logic                       busy,
   output logic                       done,
   output logic [COUNT_WIDTH-1:0]     burst_count,
   output logic [COUNT_WIDTH-1:0]     drop_count
);

   typedef enum logic [2:0] {IDLE, ARMED, PASS, HOLDOFF, DROP} state_t;

   state_t                   state, state_n;
   logic                     in_burst;
   logic                     disarm_pend, pend_n;
   logic [HOLDOFF_WIDTH-1:0] hold_cnt, hold_n;
   logic [HOLDOFF_WIDTH-1:0] hold_lat, hold_lat_n;
   logic [COUNT_WIDTH-1:0]   num_lat, num_lat_n;
   logic [COUNT_WIDTH-1:0]   burst_n, drop_n;
   logic [COUNT_WIDTH-1:0]   burst_inc, drop_inc;
   logic                     done_n;
   logic                     burst_end;

   logic                     forwarding;
   logic                     s_tready;
   logic                     s_hs;
   logic                     last_hs;
   logic                     beat_hs;
   logic [DATA_WIDTH-1:0]    pass_data;

   assign forwarding = (state == ARMED) || (state == PASS);
   assign s_tready   = forwarding ? m_axis.tready : 1'b1;
   assign s_hs       = s_axis.tvalid & s_tready;
   assign last_hs    = s_hs & s_axis.tlast;
   assign beat_hs    = s_hs & ~s_axis.tlast;

   assign pass_data     = s_axis.tdata;
   assign s_axis.tready = s_tready;
   assign m_axis.tvalid = forwarding & s_axis.tvalid;
   assign m_axis.tdata  = pass_data;
   assign m_axis.tlast  = forwarding & s_axis.tlast;

   assign busy = (state != IDLE);

   assign burst_inc = (burst_count == '1) ? burst_count : burst_count + COUNT_WIDTH'(1);
   assign drop_inc  = (drop_count  == '1) ? drop_count  : drop_count  + COUNT_WIDTH'(1);

   always_comb begin
      state_n    = state;
      burst_n    = burst_count;
      drop_n     = drop_count;
      hold_n     = hold_cnt;
      pend_n     = disarm_pend;
      done_n     = 1'b0;
      num_lat_n  = num_lat;
      hold_lat_n = hold_lat;
      burst_end  = 1'b0;

      case (state)
         IDLE: begin
            if (arm && !disarm) begin
               num_lat_n  = cfg_num_bursts;
               hold_lat_n = cfg_holdoff;
               burst_n    = '0;
               drop_n     = '0;
               pend_n     = 1'b0;
               // A beat accepted in the arming cycle already belongs to a burst we missed.
               state_n    = (in_burst || beat_hs) ? DROP : ARMED;
            end
         end
         ARMED: begin
            if (last_hs) begin
               burst_end = 1'b1;
            end else if (beat_hs) begin
               state_n = PASS;
               pend_n  = disarm;
            end else if (disarm) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         PASS: begin
            if (last_hs) begin
               burst_end = 1'b1;
            end else if (disarm) begin
               pend_n = 1'b1;
            end
         end
         HOLDOFF: begin
            hold_n = hold_cnt - HOLDOFF_WIDTH'(1);
            if (last_hs) begin
               drop_n = drop_inc;
            end
            if (disarm) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (hold_cnt == HOLDOFF_WIDTH'(1)) begin
               // Any beat on the expiry cycle (first or last) means the stream is not at a
               // clean burst gap, so the remainder of that traffic is drained.
               state_n = (!in_burst && !s_hs) ? ARMED : DROP;
            end
         end
         DROP: begin
            if (last_hs) begin
               drop_n  = drop_inc;
               state_n = ARMED;
            end
            if (disarm) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (burst_end) begin
         burst_n = burst_inc;
         pend_n  = 1'b0;
         if (disarm_pend || disarm || ((num_lat != '0) && (burst_inc == num_lat))) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end else if (hold_lat == '0) begin
            state_n = ARMED;
         end else begin
            hold_n  = hold_lat;
            state_n = HOLDOFF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_burst    <= 1'b0;
         disarm_pend <= 1'b0;
         hold_cnt    <= '0;
         hold_lat    <= '0;
         num_lat     <= '0;
         burst_count <= '0;
         drop_count  <= '0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         disarm_pend <= pend_n;
         hold_cnt    <= hold_n;
         hold_lat    <= hold_lat_n;
         num_lat     <= num_lat_n;
         burst_count <= burst_n;
         drop_count  <= drop_n;
         done        <= done_n;
         if (s_hs) begin
            in_burst <= ~s_axis.tlast;
         end
      end
   end

endmodule

// File: tb/tb_axis_peak_burst_sched.sv
// Self-checking bench for axis_peak_burst_sched: random bursts scored against a
// burst-level model of arming, holdoff windows and drop accounting.
module tb_axis_peak_burst_sched;
   localparam int DW = 128;
   localparam int HW = 16;
   localparam int CW = 16;
   localparam int BL = 32;

   typedef struct {
      int s;
      int e;
      int idx;
   } burst_t;

   logic          clk = 1'b0;
   logic          rst, arm, disarm;
   logic [CW-1:0] cfg_num_bursts;
   logic [HW-1:0] cfg_holdoff;
   logic          busy, done;
   logic [CW-1:0] burst_count, drop_count;

   axis_peak_burst_sched_if #(.DATA_WIDTH(DW)) s_if ();
   axis_peak_burst_sched_if #(.DATA_WIDTH(DW)) m_if ();

   axis_peak_burst_sched #(
      .DATA_WIDTH(DW), .HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
      .cfg_num_bursts(cfg_num_bursts), .cfg_holdoff(cfg_holdoff),
      .s_axis(s_if), .m_axis(m_if),
      .busy(busy), .done(done), .burst_count(burst_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit rnd_ready = 1'b0;
   bit mon_en  = 1'b0;
   bit mon_clr = 1'b0;

   burst_t        sb_q[$];
   logic [DW-1:0] sdat_q[$];
   logic [DW-1:0] mdat_q[$];
   bit            mlast_q[$];
   int            done_q[$];
   int            arm_q[$];
   int            rdy_bad = 0;
   bit            mon_inb = 1'b0;
   int            cur_s = 0;
   int            cur_idx = 0;
   int            gaps[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Event log; an entry stamped c takes effect at the clock edge that ends cycle c.
   always @(negedge clk) begin
      if (mon_clr) begin
         sb_q.delete(); sdat_q.delete(); mdat_q.delete(); mlast_q.delete();
         done_q.delete(); arm_q.delete();
         rdy_bad = 0; mon_inb = 1'b0;
      end else if (mon_en) begin
         if (s_if.tvalid && s_if.tready) begin
            if (!mon_inb) begin
               cur_s   = cyc;
               cur_idx = sdat_q.size();
            end
            sdat_q.push_back(s_if.tdata);
            if (s_if.tlast) begin
               sb_q.push_back('{cur_s, cyc, cur_idx});
               mon_inb = 1'b0;
            end else begin
               mon_inb = 1'b1;
            end
         end
         if (m_if.tvalid && m_if.tready) begin
            mdat_q.push_back(m_if.tdata);
            mlast_q.push_back(m_if.tlast);
         end
         if (m_if.tvalid && (s_if.tready !== m_if.tready)) rdy_bad++;
         if (done) done_q.push_back(cyc);
         if (arm) arm_q.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input bit last);
      bit hs = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = last;
      for (int t = 0; t < 2000 && !hs; t++) begin
         @(negedge clk);
         hs = s_if.tready;
         @(posedge clk); #1;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      if (!hs) begin
         n_tests++; n_fail++;
         $display("FAIL beat_timeout: handshake got 0 want 1 within 2000 cycles");
      end
   endtask

   task automatic send_burst(input bit bubbles);
      for (int i = 0; i < BL; i++) begin
         if (bubbles && $urandom_range(0, 7) == 0) idle(1);
         drive_beat(rand_data(), i == BL - 1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; arm = 1'b0; disarm = 1'b0;
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      mon_clr = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      mon_clr = 1'b0;
      mon_en  = 1'b1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      idle(1);
      arm = 1'b0;
   endtask

   // Burst-level reference: a burst is forwarded iff its first beat lands at or after
   // the time the scheduler is ready again; drops extend that time as the rules say.
   task automatic check_session(input string name, input int n, input int h);
      int A = (arm_q.size() > 0) ? arm_q[0] : 0;
      int armed_from = A + 1;
      bit active = (arm_q.size() > 0);
      bit drop_next = 1'b0;
      int fwd = 0, drops = 0, exp_done = -1, mism = 0;
      logic [DW-1:0] exp_d[$];
      bit exp_l[$];
      for (int k = 0; k < sb_q.size(); k++) begin
         if (!active) break;
         if (sb_q[k].e < A) continue;
         if (sb_q[k].s >= armed_from && !drop_next) begin
            fwd++;
            for (int j = 0; j < BL; j++) begin
               exp_d.push_back(sdat_q[sb_q[k].idx + j]);
               exp_l.push_back(j == BL - 1);
            end
            if (n != 0 && fwd == n) begin
               active = 1'b0;
               exp_done = sb_q[k].e + 1;
            end else begin
               armed_from = sb_q[k].e + h + 1;
            end
         end else begin
            if (sb_q[k].e > A) drops++;
            if (drop_next) begin
               drop_next = 1'b0;
               armed_from = sb_q[k].e + 1;
            end else if (sb_q[k].e > armed_from - 1) begin
               armed_from = sb_q[k].e + 1;
            end else if (sb_q[k].e == armed_from - 1) begin
               drop_next = 1'b1;
            end
         end
      end

      n_tests++;
      if (mdat_q.size() !== exp_d.size()) begin
         n_fail++;
         $display("FAIL %s beats: got %0d want %0d", name, mdat_q.size(), exp_d.size());
      end
      for (int i = 0; i < mdat_q.size() && i < exp_d.size(); i++)
         if (mdat_q[i] !== exp_d[i] || mlast_q[i] !== exp_l[i]) mism++;
      n_tests++;
      if (mism !== 0) begin
         n_fail++;
         $display("FAIL %s beat_content: got %0d mismatching beats want 0", name, mism);
      end
      n_tests++;
      if (burst_count !== CW'(fwd)) begin
         n_fail++;
         $display("FAIL %s burst_count: got %0d want %0d", name, burst_count, fwd);
      end
      n_tests++;
      if (drop_count !== CW'(drops)) begin
         n_fail++;
         $display("FAIL %s drop_count: got %0d want %0d", name, drop_count, drops);
      end
      n_tests++;
      if (done_q.size() !== ((exp_done >= 0) ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s done_pulses: got %0d want %0d", name, done_q.size(), (exp_done >= 0) ? 1 : 0);
      end else if (exp_done >= 0) begin
         n_tests++;
         if (done_q[0] !== exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_q[0], exp_done);
         end
      end
      n_tests++;
      if (busy !== active) begin
         n_fail++;
         $display("FAIL %s busy: got %0b want %0b", name, busy, active);
      end
      n_tests++;
      if (rdy_bad !== 0) begin
         n_fail++;
         $display("FAIL %s tready_mirror: got %0d violations want 0", name, rdy_bad);
      end
   endtask

   task automatic run_session(input string name, input int n, input int h, input int nb,
                              input int lo, input int hi, input bit rnd, input int pre,
                              input int arm_dly);
      do_reset();
      cfg_num_bursts = CW'(n);
      cfg_holdoff    = HW'(h);
      rnd_ready      = rnd;
      clear_logs();
      if (pre >= 0) begin
         for (int i = 0; i < BL; i++) begin
            if (i == pre) arm = 1'b1;
            drive_beat(rand_data(), i == BL - 1);
            arm = 1'b0;
         end
      end else begin
         idle(arm_dly);
         pulse_arm();
      end
      for (int b = 0; b < nb; b++) begin
         idle((gaps.size() > 0) ? gaps.pop_front() : $urandom_range(lo, hi));
         send_burst(rnd);
      end
      idle(h + 40);
      mon_en = 1'b0;
      check_session(name, n, h);
   endtask

   task automatic test_reset();
      rst = 1'b1; arm = 1'b0; disarm = 1'b0;
      cfg_num_bursts = '0; cfg_holdoff = '0;
      s_if.tvalid = 1'b1; s_if.tlast = 1'b0; s_if.tdata = rand_data();
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          burst_count !== '0 || drop_count !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got mv=%0b sr=%0b busy=%0b done=%0b bc=%0d dc=%0d want 0 1 0 0 0 0",
                  m_if.tvalid, s_if.tready, busy, done, burst_count, drop_count);
      end
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_num_bursts();
      gaps = '{0, 0, 0};
      run_session("num_bursts", 2, 0, 3, 0, 0, 1'b0, -1, 2);
   endtask

   task automatic test_holdoff();
      gaps = '{0, 8, 120};
      run_session("holdoff", 0, 100, 3, 0, 0, 1'b0, -1, 2);
   endtask

   task automatic test_holdoff_mid_burst();
      gaps = '{0, 34, 5};
      run_session("holdoff_mid", 0, 40, 3, 0, 0, 1'b0, -1, 2);
   endtask

   task automatic test_backpressure();
      gaps.delete();
      run_session("backpressure", 0, 5, 4, 0, 10, 1'b1, -1, 1);
   endtask

   task automatic test_arm_mid_burst();
      gaps = '{3};
      run_session("arm_mid_burst", 0, 0, 1, 0, 0, 1'b0, 10, 0);
   endtask

   task automatic test_disarm();
      do_reset();
      cfg_num_bursts = '0; cfg_holdoff = '0; rnd_ready = 1'b0;
      clear_logs();
      pulse_arm();
      idle(2);
      for (int i = 0; i < BL; i++) begin
         if (i == 10) disarm = 1'b1;
         drive_beat(rand_data(), i == BL - 1);
         disarm = 1'b0;
      end
      idle(3);
      mon_en = 1'b0;
      n_tests++;
      if (mdat_q.size() !== BL || mlast_q.size() == 0 || mlast_q[mlast_q.size() - 1] !== 1'b1) begin
         n_fail++;
         $display("FAIL disarm_beats: got %0d beats want %0d ending in tlast", mdat_q.size(), BL);
      end
      n_tests++;
      if (done_q.size() !== 1 || sb_q.size() !== 1 || done_q[0] !== sb_q[0].e + 1) begin
         n_fail++;
         $display("FAIL disarm_done: got %0d pulses want 1 pulse one cycle after tlast", done_q.size());
      end
      n_tests++;
      if (busy !== 1'b0 || burst_count !== CW'(1)) begin
         n_fail++;
         $display("FAIL disarm_idle: got busy=%0b bc=%0d want 0 1", busy, burst_count);
      end

      clear_logs();
      arm = 1'b1; disarm = 1'b1;
      idle(1);
      arm = 1'b0; disarm = 1'b0;
      idle(1);
      send_burst(1'b0);
      idle(3);
      mon_en = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || done_q.size() !== 0 || mdat_q.size() !== 0) begin
         n_fail++;
         $display("FAIL arm_disarm_same: got busy=%0b done=%0d fwd=%0d want 0 0 0",
                  busy, done_q.size(), mdat_q.size());
      end
   endtask

   task automatic test_reset_in_pass();
      do_reset();
      cfg_num_bursts = '0; cfg_holdoff = '0; rnd_ready = 1'b0;
      pulse_arm();
      idle(1);
      send_burst(1'b0);
      idle(2);
      for (int i = 0; i < 6; i++) drive_beat(rand_data(), 1'b0);
      s_if.tvalid = 1'b1;
      s_if.tdata  = rand_data();
      @(negedge clk);
      n_tests++;
      if (m_if.tvalid !== 1'b1 || burst_count !== CW'(1)) begin
         n_fail++;
         $display("FAIL pass_before_reset: got mv=%0b bc=%0d want 1 1", m_if.tvalid, burst_count);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          burst_count !== '0 || drop_count !== '0) begin
         n_fail++;
         $display("FAIL reset_in_pass: got mv=%0b sr=%0b busy=%0b done=%0b bc=%0d dc=%0d want 0 1 0 0 0 0",
                  m_if.tvalid, s_if.tready, busy, done, burst_count, drop_count);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      s_if.tvalid = 1'b0;
   endtask

   task automatic test_random();
      gaps.delete();
      for (int r = 0; r < 6; r++) begin
         run_session($sformatf("rand%0d", r), $urandom_range(0, 3), $urandom_range(0, 60), 5, 0, 50,
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BL - 1)) : -1,
                     $urandom_range(0, 5));
      end
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; disarm = 1'b0;
      cfg_num_bursts = '0; cfg_holdoff = '0;
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
      @(posedge clk); #1;
      test_reset();
      test_num_bursts();
      test_holdoff();
      test_holdoff_mid_burst();
      test_backpressure();
      test_arm_mid_burst();
      test_disarm();
      test_reset_in_pass();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
